// File: rtl/bird_pkg.sv
// Shared types and default physics constants for the bird game core.
package bird_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLAY   = 2'd1,
    PAUSED = 2'd2,
    DEAD   = 2'd3
  } gamestate_e;

  typedef logic [3:0] bcd_digit_t;

  localparam int DEF_Y_W      = 10;
  localparam int DEF_VEL_W    = 6;
  localparam int DEF_START_Y  = 240;
  localparam int DEF_CEIL_Y   = 0;
  localparam int DEF_FLOOR_Y  = 440;
  localparam int DEF_GRAVITY  = 1;
  localparam int DEF_FLAP_VEL = 8;
  localparam int DEF_MAX_FALL = 10;
  localparam int DEF_DIGITS   = 4;

endpackage

// File: rtl/bcd_score_counter.sv
// Saturating packed-BCD up counter; sticks at all nines.
module bcd_score_counter
  import bird_pkg::*;
#(
  parameter int DIGITS = DEF_DIGITS
) (
  input  logic                clk,
  input  logic                rst_i,
  input  logic                inc_i,
  input  logic                clear_i,
  output logic [4*DIGITS-1:0] count_o
);

  bcd_digit_t [DIGITS-1:0] cnt_q, cnt_d;
  logic                    all_nines;

  always_comb begin
    all_nines = 1'b1;
    for (int i = 0; i < DIGITS; i++)
      if (cnt_q[i] != 4'd9) all_nines = 1'b0;
  end

  // Carry ripples digit by digit; a digit that does not wrap absorbs it.
  always_comb begin
    logic c;
    c     = inc_i & ~all_nines;
    cnt_d = cnt_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (cnt_q[i] == 4'd9) begin
          cnt_d[i] = 4'd0;
        end else begin
          cnt_d[i] = cnt_q[i] + 4'd1;
          c        = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i || clear_i) cnt_q <= '0;
    else                  cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/bird_game_core.sv
// Frame-rate bird physics, game-state machine and BCD score.
module bird_game_core
  import bird_pkg::*;
#(
  parameter int Y_W      = DEF_Y_W,
  parameter int VEL_W    = DEF_VEL_W,
  parameter int START_Y  = DEF_START_Y,
  parameter int CEIL_Y   = DEF_CEIL_Y,
  parameter int FLOOR_Y  = DEF_FLOOR_Y,
  parameter int GRAVITY  = DEF_GRAVITY,
  parameter int FLAP_VEL = DEF_FLAP_VEL,
  parameter int MAX_FALL = DEF_MAX_FALL,
  parameter int DIGITS   = DEF_DIGITS
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                frame_tick,
  input  logic                flap,
  input  logic                pause,
  input  logic                pipe_pass,
  input  logic                collide,
  output logic [Y_W-1:0]      y,
  output logic [VEL_W-1:0]    vel,
  output logic [1:0]          gamestate,
  output logic [4*DIGITS-1:0] score
);

  localparam int YX = Y_W + 2;
  localparam logic signed [VEL_W:0]  GRAV_X  = (VEL_W+1)'(GRAVITY);
  localparam logic signed [VEL_W:0]  FLAP_X  = (VEL_W+1)'(FLAP_VEL);
  localparam logic signed [VEL_W:0]  MAXF_X  = (VEL_W+1)'(MAX_FALL);
  localparam logic signed [YX-1:0]   FLOOR_X = YX'(FLOOR_Y);
  localparam logic signed [YX-1:0]   CEIL_X  = YX'(CEIL_Y);
  localparam logic [Y_W-1:0]         START_V = Y_W'(START_Y);
  localparam logic [Y_W-1:0]         FLOOR_V = Y_W'(FLOOR_Y);
  localparam logic [Y_W-1:0]         CEIL_V  = Y_W'(CEIL_Y);

  logic [1:0] flap_sync_q, pause_sync_q;
  logic       flap_prev_q, pause_prev_q;
  logic       flap_edge_q, pause_edge_q;

  gamestate_e              state_q, state_d;
  logic [Y_W-1:0]          y_q, y_d;
  logic signed [VEL_W-1:0] vel_q, vel_d;
  logic                    pend_q, pend_d;

  logic signed [VEL_W:0]   vel_inc, vel_n;
  logic signed [YX-1:0]    y_n;
  logic                    do_phys, hit_floor;

  always_ff @(posedge clk) begin
    if (clr) begin
      flap_sync_q  <= '0;
      pause_sync_q <= '0;
      flap_prev_q  <= 1'b0;
      pause_prev_q <= 1'b0;
      flap_edge_q  <= 1'b0;
      pause_edge_q <= 1'b0;
    end else begin
      flap_sync_q  <= {flap_sync_q[0], flap};
      pause_sync_q <= {pause_sync_q[0], pause};
      flap_prev_q  <= flap_sync_q[1];
      pause_prev_q <= pause_sync_q[1];
      flap_edge_q  <= flap_sync_q[1] & ~flap_prev_q;
      pause_edge_q <= pause_sync_q[1] & ~pause_prev_q;
    end
  end

  // Collide and pause both pre-empt a same-cycle physics step.
  assign do_phys = (state_q == PLAY) & frame_tick & ~collide & ~pause_edge_q;

  always_comb begin
    vel_inc   = {vel_q[VEL_W-1], vel_q} + GRAV_X;
    vel_n     = pend_q ? -FLAP_X : ((vel_inc > MAXF_X) ? MAXF_X : vel_inc);
    y_n       = {2'b00, y_q} + {{(YX-VEL_W-1){vel_n[VEL_W]}}, vel_n};
    hit_floor = (y_n >= FLOOR_X);
    y_d       = y_q;
    vel_d     = vel_q;
    pend_d    = pend_q;
    unique case (state_q)
      IDLE: begin
        y_d    = START_V;
        vel_d  = '0;
        pend_d = flap_edge_q;
      end
      PLAY: begin
        if (do_phys) begin
          pend_d = 1'b0;
          if (hit_floor) begin
            y_d   = FLOOR_V;
            vel_d = '0;
          end else if (y_n < CEIL_X) begin
            y_d   = CEIL_V;
            vel_d = '0;
          end else begin
            y_d   = y_n[Y_W-1:0];
            vel_d = vel_n[VEL_W-1:0];
          end
        end
        if (flap_edge_q && !pause_edge_q && !collide) pend_d = 1'b1;
      end
      PAUSED: ;
      DEAD: begin
        if (flap_edge_q) begin
          y_d    = START_V;
          vel_d  = '0;
          pend_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (flap_edge_q) state_d = PLAY;
      PLAY: begin
        if (collide)                 state_d = DEAD;
        else if (pause_edge_q)       state_d = PAUSED;
        else if (do_phys && hit_floor) state_d = DEAD;
      end
      PAUSED: if (pause_edge_q) state_d = PLAY;
      DEAD:   if (flap_edge_q)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      y_q     <= START_V;
      vel_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      vel_q   <= vel_d;
      pend_q  <= pend_d;
    end
  end

  bcd_score_counter #(.DIGITS(DIGITS)) u_score (
    .clk     (clk),
    .rst_i   (clr),
    .inc_i   ((state_q == PLAY) & pipe_pass & ~collide),
    .clear_i ((state_q == DEAD) & flap_edge_q),
    .count_o (score)
  );

  assign y         = y_q;
  assign vel       = vel_q;
  assign gamestate = state_q;

endmodule

// File: tb/tb_bird_game_core.sv
// Directed bench for bird_game_core with a cycle-level reference model.
module tb_bird_game_core;

  localparam int START = 240, CEIL = 0, FLOOR = 440;
  localparam int GRAV = 1, FLAPV = 8, MAXF = 10, MAXSCORE = 9999;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        frame_tick = 1'b0, flap = 1'b0, pause = 1'b0;
  logic        pipe_pass = 1'b0, collide = 1'b0;
  logic [9:0]  y;
  logic [5:0]  vel;
  logic [1:0]  gamestate;
  logic [15:0] score;

  int nvec = 0, nerr = 0;

  bird_game_core dut (
    .clk(clk), .clr(clr), .frame_tick(frame_tick), .flap(flap), .pause(pause),
    .pipe_pass(pipe_pass), .collide(collide),
    .y(y), .vel(vel), .gamestate(gamestate), .score(score)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int want);
    nvec++;
    if (got != want) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, want, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t;
    t = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Reference model: buttons reach the game 3 cycles late as rising edges.
  int m_st, m_y, m_vel, m_pend, m_score;
  bit [4:0] fh, ph;

  always @(posedge clk) begin
    bit fe, pe;
    int vn, yn;
    if (clr) begin
      m_st = 0; m_y = START; m_vel = 0; m_pend = 0; m_score = 0;
      fh = '0; ph = '0;
    end else begin
      fh = {fh[3:0], flap};
      ph = {ph[3:0], pause};
      fe = fh[3] & ~fh[4];
      pe = ph[3] & ~ph[4];
      case (m_st)
        0: if (fe) begin m_st = 1; m_pend = 1; end
        1: begin
          if (collide) m_st = 3;
          else begin
            if (pipe_pass && m_score < MAXSCORE) m_score++;
            if (pe) m_st = 2;
            else begin
              if (frame_tick) begin
                vn = m_pend ? -FLAPV : ((m_vel + GRAV > MAXF) ? MAXF : m_vel + GRAV);
                yn = m_y + vn;
                m_pend = 0;
                if (yn >= FLOOR)   begin m_y = FLOOR; m_vel = 0; m_st = 3; end
                else if (yn < CEIL) begin m_y = CEIL; m_vel = 0; end
                else begin m_y = yn; m_vel = vn; end
              end
              if (fe) m_pend = 1;
            end
          end
        end
        2: if (pe) m_st = 1;
        default: if (fe) begin
          m_st = 0; m_y = START; m_vel = 0; m_score = 0; m_pend = 0;
        end
      endcase
    end
    #1;
    chk("model_y", int'(y), m_y);
    chk("model_vel", int'($signed(vel)), m_vel);
    chk("model_state", int'(gamestate), m_st);
    chk("model_score", int'(score), int'(to_bcd(m_score)));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic press_flap();
    flap = 1'b1; cyc(1); flap = 1'b0; cyc(5);
  endtask
  task automatic press_pause();
    pause = 1'b1; cyc(1); pause = 1'b0; cyc(5);
  endtask
  task automatic tick();
    frame_tick = 1'b1; cyc(1); frame_tick = 1'b0;
  endtask
  task automatic pipes(input int n);
    pipe_pass = 1'b1; cyc(n); pipe_pass = 1'b0;
  endtask

  initial begin
    cyc(3);
    clr = 1'b0;
    chk("reset_y", int'(y), 240);
    chk("reset_vel", int'($signed(vel)), 0);
    chk("reset_state", int'(gamestate), 0);
    chk("reset_score", int'(score), 0);

    press_flap();
    chk("start_state", int'(gamestate), 1);
    tick();
    chk("flap1_vel", int'($signed(vel)), -8);
    chk("flap1_y", int'(y), 232);
    tick();
    chk("flap2_vel", int'($signed(vel)), -7);
    chk("flap2_y", int'(y), 225);

    for (int i = 0; i < 100 && gamestate != 2'd3; i++) tick();
    chk("floor_state", int'(gamestate), 3);
    chk("floor_y", int'(y), 440);
    chk("floor_vel", int'($signed(vel)), 0);

    press_flap();
    chk("restart_state", int'(gamestate), 0);
    chk("restart_y", int'(y), 240);
    press_flap();
    chk("replay_state", int'(gamestate), 1);

    for (int i = 0; i < 32; i++) begin
      flap = 1'b1; cyc(1); flap = 1'b0; cyc(4);
      tick();
    end
    chk("ceil_y", int'(y), 0);
    chk("ceil_vel", int'($signed(vel)), 0);
    chk("ceil_state", int'(gamestate), 1);

    pipes(3);
    chk("score3", int'(score), 16'h0003);
    press_pause();
    chk("paused_state", int'(gamestate), 2);
    for (int i = 0; i < 5; i++) begin tick(); cyc(1); end
    pipes(1); cyc(1); pipes(1);
    collide = 1'b1; cyc(1); collide = 1'b0;
    press_flap();
    chk("paused_y", int'(y), 0);
    chk("paused_vel", int'($signed(vel)), 0);
    chk("paused_score", int'(score), 16'h0003);
    chk("paused_hold", int'(gamestate), 2);
    press_pause();
    chk("resume_state", int'(gamestate), 1);

    pipes(96);
    chk("score99", int'(score), 16'h0099);
    pipes(1);
    chk("score100", int'(score), 16'h0100);

    tick();
    chk("fall_y", int'(y), 1);
    chk("fall_vel", int'($signed(vel)), 1);
    collide = 1'b1; frame_tick = 1'b1; pipe_pass = 1'b1;
    cyc(1);
    collide = 1'b0; frame_tick = 1'b0; pipe_pass = 1'b0;
    chk("collide_state", int'(gamestate), 3);
    chk("collide_y", int'(y), 1);
    chk("collide_score", int'(score), 16'h0100);
    press_flap();
    chk("dead_idle_state", int'(gamestate), 0);
    chk("dead_idle_y", int'(y), 240);
    chk("dead_idle_score", int'(score), 0);

    press_flap();
    pipes(9999);
    chk("score9999", int'(score), 16'h9999);
    pipes(1);
    chk("score_sat", int'(score), 16'h9999);

    tick();
    chk("flap3_y", int'(y), 232);
    pause = 1'b1; flap = 1'b1; cyc(1); pause = 1'b0; flap = 1'b0; cyc(5);
    chk("pauseflap_state", int'(gamestate), 2);
    press_pause();
    tick();
    chk("flapdrop_vel", int'($signed(vel)), -7);
    chk("flapdrop_y", int'(y), 225);

    clr = 1'b1; cyc(1); clr = 1'b0;
    chk("clr_state", int'(gamestate), 0);
    chk("clr_y", int'(y), 240);
    chk("clr_score", int'(score), 0);
    cyc(3);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
